if_fetch: RTL and testbench

Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It generates the PC and issues word fetches to instruction memory over a req/gnt/rvalid handshake. Returned instructions are held in a small FIFO and presented to IF/ID as a (pc, inst, valid) triple. It honours decode-stage stalls and branch redirects, and discards in-flight fetches on a redirect.

---
 rtl/if_fetch.sv | 198 +++++++++++++++++++
 tb/tb_if_fetch.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: issues word fetches over a req/gnt/rvalid handshake and
// buffers returned instructions in a small FIFO that presents (pc, inst, valid) to IF/ID.
module if_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

    typedef enum logic {
        StReq,
        StWait
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     req_pc_q, req_pc_d;
    logic            kill_q, kill_d;
    logic [31:0]     fifo_pc_q   [FIFO_DEPTH];
    logic [31:0]     fifo_pc_d   [FIFO_DEPTH];
    logic [31:0]     fifo_inst_q [FIFO_DEPTH];
    logic [31:0]     fifo_inst_d [FIFO_DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic            fetch_go;
    logic            push;
    logic            pop;
    logic            unused_target_lsbs;

    assign unused_target_lsbs = ^branch_target_i[1:0];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StReq;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StReq: begin
                if (fetch_go) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                // Any response ends the wait, whether it is kept, killed or flushed.
                if (imem_rvalid_i) begin
                    state_d = StReq;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        imem_req_o  = 1'b0;
        imem_addr_o = pc_q;
        unique case (state_q)
            StReq: begin
                // Nothing can be in flight in StReq, so free space is just DEPTH - count.
                imem_req_o = !rst && !branch_flag_i && (count_q < DepthCnt);
            end
            StWait: begin
                imem_req_o = 1'b0;
            end
        endcase
    end

    assign fetch_go = imem_req_o && imem_gnt_i;
    assign push     = (state_q == StWait) && imem_rvalid_i && !kill_q && !branch_flag_i;
    assign pop      = if_valid && !stall_i && !branch_flag_i;

    // ------------------------------------------------------------------
    // PC, request PC and kill flag
    // ------------------------------------------------------------------
    always_comb begin
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        kill_d   = kill_q;
        if (branch_flag_i) begin
            pc_d = {branch_target_i[31:2], 2'b00};
            if (state_q == StWait) begin
                kill_d = !imem_rvalid_i;
            end
        end else begin
            if (fetch_go) begin
                pc_d     = pc_q + 32'd4;
                req_pc_d = pc_q;
            end
            if ((state_q == StWait) && imem_rvalid_i) begin
                kill_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
            kill_q   <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            kill_q   <= kill_d;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    always_comb begin
        fifo_pc_d   = fifo_pc_q;
        fifo_inst_d = fifo_inst_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        if (branch_flag_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                fifo_pc_d[wr_ptr_q]   = req_pc_q;
                fifo_inst_d[wr_ptr_q] = imem_rdata_i;
                wr_ptr_d              = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the outputs are gated by count.
    always_ff @(posedge clk) begin
        fifo_pc_q   <= fifo_pc_d;
        fifo_inst_q <= fifo_inst_d;
    end

    // ------------------------------------------------------------------
    // IF/ID outputs
    // ------------------------------------------------------------------
    always_comb begin
        if_valid = (count_q != '0);
        if_pc    = 32'h0;
        if_inst  = 32'h0;
        if (if_valid) begin
            if_pc   = fifo_pc_q[rd_ptr_q];
            if_inst = fifo_inst_q[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios plus random traffic, checked every cycle
// against a queue-based model of the instruction stream and a simple memory model.
module tb_if_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;

    always #5 clk = ~clk;

    if_fetch #(
        .RESET_PC  (RESET_PC),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .branch_flag_i  (branch_flag_i),
        .branch_target_i(branch_target_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_gnt_i     (imem_gnt_i),
        .imem_rvalid_i  (imem_rvalid_i),
        .imem_rdata_i   (imem_rdata_i),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .if_valid       (if_valid)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: expected fetch PC, one outstanding request tagged with a
    // redirect epoch, and the queue of instructions waiting for IF/ID.
    logic [31:0] m_pc;
    bit          m_out;
    int          m_epoch;
    int          m_req_epoch;
    logic [31:0] m_req_addr;
    logic [63:0] m_q[$];

    // Memory model.
    bit          mem_pend;
    int          mem_delay;
    logic [31:0] mem_addr;
    int          mem_lat;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc     = RESET_PC;
        m_out    = 1'b0;
        m_epoch  = 0;
        m_q.delete();
        mem_pend = 1'b0;
    endtask

    // Called at a negedge; holds reset for n cycles and returns at a negedge with rst low.
    task automatic do_reset(input int n);
        rst             = 1'b1;
        stall_i         = 1'b0;
        branch_flag_i   = 1'b0;
        branch_target_i = 32'h0;
        imem_gnt_i      = 1'b1;
        imem_rvalid_i   = 1'b0;
        imem_rdata_i    = 32'h0;
        #1;
        check1("req_in_reset", imem_req_o, 1'b0);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b0;
        model_reset();
    endtask

    // One clock cycle: drive inputs, check all outputs against the model, advance both.
    task automatic step(input bit stall, input bit br, input logic [31:0] tgt, input bit gnt);
        bit          rv;
        bit          exp_valid;
        bit          exp_req;
        bit          go_model;
        bit          go_mem;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
        rv              = mem_pend && (mem_delay == 0);
        stall_i         = stall;
        branch_flag_i   = br;
        branch_target_i = tgt;
        imem_gnt_i      = gnt;
        imem_rvalid_i   = rv;
        imem_rdata_i    = rv ? mem_word(mem_addr) : $urandom;
        #1;
        exp_valid = (m_q.size() != 0);
        exp_req   = !m_out && !br && (m_q.size() < DEPTH);
        exp_pc    = 32'h0;
        exp_inst  = 32'h0;
        if (exp_valid) begin
            {exp_pc, exp_inst} = m_q[0];
        end
        check1("imem_req", imem_req_o, exp_req);
        check32("imem_addr", imem_addr_o, m_pc);
        check1("if_valid", if_valid, exp_valid);
        check32("if_pc", if_pc, exp_pc);
        check32("if_inst", if_inst, exp_inst);

        go_model = exp_req && gnt;
        go_mem   = imem_req_o && gnt;
        if (br) begin
            m_q.delete();
            m_pc = {tgt[31:2], 2'b00};
            m_epoch++;
            if (rv) m_out = 1'b0;
        end else begin
            if (exp_valid && !stall) void'(m_q.pop_front());
            if (rv) begin
                if (m_req_epoch == m_epoch) m_q.push_back({m_req_addr, mem_word(m_req_addr)});
                m_out = 1'b0;
            end
            if (go_model) begin
                m_req_addr  = m_pc;
                m_req_epoch = m_epoch;
                m_out       = 1'b1;
                m_pc        = m_pc + 32'd4;
            end
        end

        if (rv) mem_pend = 1'b0;
        else if (mem_pend) mem_delay--;
        if (go_mem) begin
            mem_pend  = 1'b1;
            mem_addr  = imem_addr_o;
            mem_delay = mem_lat;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Sequential fetch, zero-latency memory.
        do_reset(2);
        check1("rst_valid", if_valid, 1'b0);
        check32("rst_addr", imem_addr_o, RESET_PC);
        mem_lat = 0;
        repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Stall with a full FIFO, then release.
        do_reset(1);
        repeat (10) step(1'b1, 1'b0, 32'h0, 1'b1);
        check1("stall_req", imem_req_o, 1'b0);
        check32("stall_pc", imem_addr_o, 32'h8);
        check32("stall_head", if_pc, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check32("release_head", if_pc, 32'h4);
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect while waiting; stale response three cycles after grant.
        do_reset(1);
        mem_lat = 2;
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h100, 1'b1);
        check32("br_wait_pc", imem_addr_o, 32'h100);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check1("stale_dropped", if_valid, 1'b0);
        check1("req_after_kill", imem_req_o, 1'b1);
        mem_lat = 0;
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect coincident with rvalid, FIFO non-empty, unaligned target.
        do_reset(1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 32'h203, 1'b1);
        check1("flush_valid", if_valid, 1'b0);
        check32("flush_addr", imem_addr_o, 32'h200);
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);

        // PC wrap.
        do_reset(1);
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check32("wrap_addr", imem_addr_o, 32'h0);
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Reset while a slow fetch is outstanding with data buffered.
        do_reset(1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        mem_lat = 3;
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        do_reset(1);
        check1("midrst_valid", if_valid, 1'b0);
        check32("midrst_pc", if_pc, 32'h0);
        check32("midrst_inst", if_inst, 32'h0);
        check32("midrst_addr", imem_addr_o, RESET_PC);
        mem_lat = 0;
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            mem_lat = $urandom_range(0, 3);
            if ($urandom_range(0, 199) == 0) begin
                do_reset(1);
            end else begin
                step($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, $urandom,
                     $urandom_range(0, 9) < 7);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
